// File: rtl/wb_merge_stage_pkg.sv
// Shared widths, partition-select codes, FSM states and the latched-op record for the writeback merge stage.
package wb_merge_stage_pkg;

  localparam int DW = 128;
  localparam int AW = 5;
  localparam int NB = DW / 8;

  localparam logic [2:0] PPP_AA = 3'b000;
  localparam logic [2:0] PPP_UU = 3'b001;
  localparam logic [2:0] PPP_DD = 3'b010;
  localparam logic [2:0] PPP_EE = 3'b011;
  localparam logic [2:0] PPP_OO = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_MERGE = 2'd2,
    S_WRITE = 2'd3
  } wb_state_t;

  typedef struct packed {
    logic [0:DW-1] result;
    logic [0:AW-1] rd;
    logic [0:NB-1] mask;
  } wb_op_t;

endpackage

// File: rtl/wb_byte_mask.sv
// Combinational decode of a partition select plus extra byte enables into a per-byte write mask.
module wb_byte_mask
  import wb_merge_stage_pkg::*;
#(
  parameter int NBYTES = 16
) (
  input  logic [0:2]        ppp,
  input  logic [0:NBYTES-1] wrbyteen,
  output logic [0:NBYTES-1] mask
);

  logic [0:NBYTES-1] part;

  always_comb begin
    part = '0;
    for (int k = 0; k < NBYTES; k++) begin
      case (ppp)
        PPP_AA:  part[k] = 1'b1;
        PPP_UU:  part[k] = (k < NBYTES / 2);
        PPP_DD:  part[k] = (k >= NBYTES / 2);
        PPP_EE:  part[k] = ((k % 2) == 0);
        PPP_OO:  part[k] = ((k % 2) == 1);
        default: part[k] = 1'b0;
      endcase
    end
  end

  assign mask = part & wrbyteen;

endmodule

// File: rtl/wb_merge_stage.sv
// Writeback stage: byte-masked read-modify-write of the destination register, one op in flight.
// Full-mask write reaches rf_we 1 cycle after accept, partial 3; ex_ready stays low until rf_wready.
module wb_merge_stage
  import wb_merge_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [0:DW-1] ex_result,
  input  logic [0:AW-1] ex_rd,
  input  logic          ex_wr_en,
  input  logic [0:2]    ex_ppp,
  input  logic [0:NB-1] ex_wrbyteen,
  output logic [0:AW-1] rf_raddr,
  output logic          rf_re,
  input  logic [0:DW-1] rf_rdata,
  output logic          rf_we,
  output logic [0:AW-1] rf_waddr,
  output logic [0:DW-1] rf_wdata,
  input  logic          rf_wready,
  output logic          fwd_valid,
  output logic [0:AW-1] fwd_rd,
  output logic [0:DW-1] fwd_data
);

  wb_state_t     state;
  wb_op_t        op;
  logic [0:NB-1] eff_mask;
  logic [0:DW-1] merged;

  wb_byte_mask #(.NBYTES(NB)) u_byte_mask (
    .ppp      (ex_ppp),
    .wrbyteen (ex_wrbyteen),
    .mask     (eff_mask)
  );

  always_comb begin
    merged = '0;
    for (int k = 0; k < NB; k++) begin
      merged[8*k +: 8] = op.mask[k] ? op.result[8*k +: 8] : rf_rdata[8*k +: 8];
    end
  end

  // The forwarded value is the raw result; merged bytes only exist once the old value is read.
  assign fwd_rd   = op.rd;
  assign fwd_data = op.result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      op        <= '0;
      ex_ready  <= 1'b1;
      rf_re     <= 1'b0;
      rf_raddr  <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      fwd_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_valid && ex_wr_en && (|eff_mask)) begin
            op        <= '{result: ex_result, rd: ex_rd, mask: eff_mask};
            ex_ready  <= 1'b0;
            fwd_valid <= 1'b1;
            if (&eff_mask) begin
              state    <= S_WRITE;
              rf_we    <= 1'b1;
              rf_waddr <= ex_rd;
              rf_wdata <= ex_result;
            end else begin
              state    <= S_READ;
              rf_re    <= 1'b1;
              rf_raddr <= ex_rd;
            end
          end
        end
        S_READ: begin
          rf_re <= 1'b0;
          state <= S_MERGE;
        end
        S_MERGE: begin
          rf_wdata <= merged;
          rf_waddr <= op.rd;
          rf_we    <= 1'b1;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          if (rf_wready) begin
            rf_we     <= 1'b0;
            fwd_valid <= 1'b0;
            ex_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
